// File: rtl/rra_grant_logger_if.sv
// Grant-logger bus: arbiter grant vector in, event stream and status out.
interface rra_grant_logger_if #(
    parameter int unsigned NUM_REQUESTS = 256,
    parameter int unsigned IDX_W        = 8,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned FIFO_DEPTH   = 8
);
    localparam int unsigned OCC_W = $clog2(FIFO_DEPTH) + 1;

    logic [NUM_REQUESTS-1:0] gnt_i;
    logic                    clr_i;
    logic                    evt_ready_i;
    logic                    evt_valid_o;
    logic [IDX_W-1:0]        evt_idx_o;
    logic [CNT_W-1:0]        evt_len_o;
    logic [OCC_W-1:0]        fifo_cnt_o;
    logic                    fifo_full_o;
    logic                    busy_o;
    logic                    ovf_o;
    logic                    onehot_err_o;

    modport master (
        output gnt_i, clr_i, evt_ready_i,
        input  evt_valid_o, evt_idx_o, evt_len_o, fifo_cnt_o, fifo_full_o,
               busy_o, ovf_o, onehot_err_o
    );

    modport slave (
        input  gnt_i, clr_i, evt_ready_i,
        output evt_valid_o, evt_idx_o, evt_len_o, fifo_cnt_o, fifo_full_o,
               busy_o, ovf_o, onehot_err_o
    );
endinterface

// File: rtl/rra_grant_logger.sv
// Records each one-hot grant tenure as {index, length} into a fall-through
// event FIFO; flags multi-hot grants and dropped events as sticky status.
module rra_grant_logger #(
    parameter int unsigned NUM_REQUESTS = 256,
    parameter int unsigned IDX_W        = 8,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input logic              Pclk_i,
    input logic              PReset_i,
    rra_grant_logger_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [NUM_REQUESTS-1:0] gnt;
    logic                    gnt_any;
    logic                    gnt_one;
    logic [IDX_W-1:0]        gnt_idx;

    logic [0:0]              state, state_nxt;
    logic [NUM_REQUESTS-1:0] held_vec, held_vec_nxt;
    logic [IDX_W-1:0]        held_idx, held_idx_nxt;
    logic [CNT_W-1:0]        len, len_nxt;
    logic                    push;
    logic                    err_set;

    logic [IDX_W-1:0]        mem_idx [FIFO_DEPTH];
    logic [CNT_W-1:0]        mem_len [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr, rd_ptr, rd_next;
    logic [OCC_W-1:0]        occ, occ_nxt;
    logic                    evt_valid;
    logic                    fifo_full;
    logic [IDX_W-1:0]        head_idx;
    logic [CNT_W-1:0]        head_len;
    logic                    busy;
    logic                    ovf;
    logic                    onehot_err;
    logic                    full_now;
    logic                    pop;
    logic                    push_ok;
    logic                    ovf_set;

    assign gnt     = bus.gnt_i;
    assign gnt_any = |gnt;
    assign gnt_one = gnt_any && ((gnt & (gnt - NUM_REQUESTS'(1))) == '0);

    // OR-encoder: exact for one-hot input, value unused otherwise
    always_comb begin
        gnt_idx = '0;
        for (int unsigned i = 0; i < NUM_REQUESTS; i++) begin
            if (gnt[i]) gnt_idx = gnt_idx | IDX_W'(i);
        end
    end

    always_ff @(posedge Pclk_i) begin
        if (PReset_i) begin
            state    <= ST_IDLE;
            held_vec <= '0;
            held_idx <= '0;
            len      <= '0;
        end else begin
            state    <= state_nxt;
            held_vec <= held_vec_nxt;
            held_idx <= held_idx_nxt;
            len      <= len_nxt;
        end
    end

    // Tenure tracking; an ending edge may immediately open the next tenure
    always_comb begin
        state_nxt    = state;
        held_vec_nxt = held_vec;
        held_idx_nxt = held_idx;
        len_nxt      = len;
        push         = 1'b0;
        err_set      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (gnt_one) begin
                    state_nxt    = ST_HOLD;
                    held_vec_nxt = gnt;
                    held_idx_nxt = gnt_idx;
                    len_nxt      = CNT_W'(1);
                end else if (gnt_any) begin
                    err_set = 1'b1;
                end
            end
            ST_HOLD: begin
                if (gnt == held_vec) begin
                    if (len != '1) len_nxt = len + CNT_W'(1);
                end else begin
                    push = 1'b1;
                    if (gnt_one) begin
                        held_vec_nxt = gnt;
                        held_idx_nxt = gnt_idx;
                        len_nxt      = CNT_W'(1);
                    end else begin
                        state_nxt = ST_IDLE;
                        err_set   = gnt_any;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign full_now = (occ == OCC_W'(FIFO_DEPTH));
    assign pop      = evt_valid && bus.evt_ready_i;
    assign push_ok  = push && (!full_now || pop);
    assign ovf_set  = push && full_now && !pop;
    assign rd_next  = rd_ptr + PTR_W'(pop);
    assign occ_nxt  = occ + OCC_W'(push_ok) - OCC_W'(pop);

    always_ff @(posedge Pclk_i) begin
        if (push_ok) begin
            mem_idx[wr_ptr] <= held_idx;
            mem_len[wr_ptr] <= len;
        end
    end

    // Head is registered; a push landing on the next head slot bypasses memory
    always_ff @(posedge Pclk_i) begin
        if (PReset_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occ        <= '0;
            evt_valid  <= 1'b0;
            fifo_full  <= 1'b0;
            head_idx   <= '0;
            head_len   <= '0;
            busy       <= 1'b0;
            ovf        <= 1'b0;
            onehot_err <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr + PTR_W'(push_ok);
            rd_ptr     <= rd_next;
            occ        <= occ_nxt;
            evt_valid  <= (occ_nxt != '0);
            fifo_full  <= (occ_nxt == OCC_W'(FIFO_DEPTH));
            busy       <= (state_nxt == ST_HOLD);
            ovf        <= ovf_set | (ovf & ~bus.clr_i);
            onehot_err <= err_set | (onehot_err & ~bus.clr_i);
            if (push_ok && (wr_ptr == rd_next)) begin
                head_idx <= held_idx;
                head_len <= len;
            end else begin
                head_idx <= mem_idx[rd_next];
                head_len <= mem_len[rd_next];
            end
        end
    end

    assign bus.evt_valid_o  = evt_valid;
    assign bus.evt_idx_o    = head_idx;
    assign bus.evt_len_o    = head_len;
    assign bus.fifo_cnt_o   = occ;
    assign bus.fifo_full_o  = fifo_full;
    assign bus.busy_o       = busy;
    assign bus.ovf_o        = ovf;
    assign bus.onehot_err_o = onehot_err;
endmodule

// File: tb/tb_rra_grant_logger.sv
// Bench for rra_grant_logger: directed scenarios plus random grants checked
// against a queue-based tenure/event model.
module tb_rra_grant_logger;
    localparam int LEN_MAX = 65535;
    localparam int DEPTH   = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         clr = 1'b0;
    logic         rdy = 1'b0;
    logic [255:0] gnt = '0;

    int total = 0;
    int bad   = 0;

    rra_grant_logger_if #(.NUM_REQUESTS(256), .IDX_W(8), .CNT_W(16), .FIFO_DEPTH(8)) bus ();
    rra_grant_logger_if #(.NUM_REQUESTS(256), .IDX_W(8), .CNT_W(4),  .FIFO_DEPTH(8)) bus_s ();

    assign bus.gnt_i         = gnt;
    assign bus.clr_i         = clr;
    assign bus.evt_ready_i   = rdy;
    assign bus_s.gnt_i       = gnt;
    assign bus_s.clr_i       = clr;
    assign bus_s.evt_ready_i = rdy;

    rra_grant_logger #(.NUM_REQUESTS(256), .IDX_W(8), .CNT_W(16), .FIFO_DEPTH(8)) dut (
        .Pclk_i(clk), .PReset_i(rst), .bus(bus)
    );
    rra_grant_logger #(.NUM_REQUESTS(256), .IDX_W(8), .CNT_W(4), .FIFO_DEPTH(8)) dut_s (
        .Pclk_i(clk), .PReset_i(rst), .bus(bus_s)
    );

    always #5 clk = ~clk;

    // Reference model: current tenure plus an event queue
    logic         m_active = 1'b0;
    logic [255:0] m_vec    = '0;
    int           m_idx    = 0;
    int           m_len    = 0;
    logic         m_ovf    = 1'b0;
    logic         m_err    = 1'b0;
    int           mq_idx[$];
    int           mq_len[$];
    int           mm_sz, mm_ei, mm_el;
    logic         mm_pop, mm_ev;

    function automatic int bit_pos(input logic [255:0] v);
        for (int i = 0; i < 256; i++) if (v[i]) return i;
        return -1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_active = 1'b0; m_len = 0; m_ovf = 1'b0; m_err = 1'b0;
            mq_idx.delete(); mq_len.delete();
        end else begin
            mm_sz  = mq_idx.size();
            mm_pop = (mm_sz != 0) && rdy;
            mm_ev  = 1'b0;
            if (clr) begin m_ovf = 1'b0; m_err = 1'b0; end
            if (m_active && gnt == m_vec) begin
                if (m_len < LEN_MAX) m_len++;
            end else begin
                if (m_active) begin mm_ev = 1'b1; mm_ei = m_idx; mm_el = m_len; end
                m_active = 1'b0;
                if ($countones(gnt) == 1) begin
                    m_active = 1'b1; m_vec = gnt; m_idx = bit_pos(gnt); m_len = 1;
                end else if ($countones(gnt) > 1) begin
                    m_err = 1'b1;
                end
            end
            if (mm_pop) begin void'(mq_idx.pop_front()); void'(mq_len.pop_front()); end
            if (mm_ev) begin
                if (mm_sz == DEPTH && !mm_pop) m_ovf = 1'b1;
                else begin mq_idx.push_back(mm_ei); mq_len.push_back(mm_el); end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; gnt = 256'h11; clr = 1'b0; rdy = 1'b0;
        tick(); tick();
        total++;
        if ({bus.evt_valid_o, bus.busy_o, bus.fifo_full_o, bus.ovf_o, bus.onehot_err_o,
             bus.fifo_cnt_o, bus.evt_idx_o, bus.evt_len_o} !== '0) begin
            bad++; $display("FAIL reset_outputs: valid=%b busy=%b full=%b ovf=%b err=%b cnt=%0d idx=%0d len=%0d, want all 0",
                bus.evt_valid_o, bus.busy_o, bus.fifo_full_o, bus.ovf_o, bus.onehot_err_o,
                bus.fifo_cnt_o, bus.evt_idx_o, bus.evt_len_o);
        end
        total++;
        if ({bus_s.evt_valid_o, bus_s.busy_o, bus_s.fifo_full_o, bus_s.ovf_o, bus_s.onehot_err_o,
             bus_s.fifo_cnt_o, bus_s.evt_idx_o, bus_s.evt_len_o} !== '0) begin
            bad++; $display("FAIL reset_outputs_sat: some output nonzero, want all 0");
        end
        rst = 1'b0; gnt = '0;
        tick();
        total++;
        if (bus.evt_valid_o !== 1'b0 || bus.fifo_cnt_o !== 4'd0) begin
            bad++; $display("FAIL post_reset: valid=%b cnt=%0d, want 0 0", bus.evt_valid_o, bus.fifo_cnt_o);
        end
    endtask

    task automatic test_two_tenures();
        int ev_i[$];
        int ev_l[$];
        int busy_cycles = 0;
        int max_cnt = 0;
        rdy = 1'b1;
        for (int c = 0; c < 12; c++) begin
            gnt = (c < 3) ? 256'h10 : (c < 5) ? 256'h02 : 256'h0;
            tick();
            if (bus.busy_o) busy_cycles++;
            if (int'(bus.fifo_cnt_o) > max_cnt) max_cnt = int'(bus.fifo_cnt_o);
            if (bus.evt_valid_o) begin ev_i.push_back(int'(bus.evt_idx_o)); ev_l.push_back(int'(bus.evt_len_o)); end
        end
        total++;
        if (ev_i.size() != 2) begin
            bad++; $display("FAIL two_tenures_count: got %0d events, want 2", ev_i.size());
        end else begin
            total++;
            if (ev_i[0] != 4 || ev_l[0] != 3) begin
                bad++; $display("FAIL two_tenures_ev0: got (%0d,%0d), want (4,3)", ev_i[0], ev_l[0]);
            end
            total++;
            if (ev_i[1] != 1 || ev_l[1] != 2) begin
                bad++; $display("FAIL two_tenures_ev1: got (%0d,%0d), want (1,2)", ev_i[1], ev_l[1]);
            end
        end
        total++;
        if (busy_cycles != 5) begin
            bad++; $display("FAIL two_tenures_busy: got %0d cycles, want 5", busy_cycles);
        end
        total++;
        if (max_cnt > 1) begin
            bad++; $display("FAIL two_tenures_occ: max occupancy %0d, want <=1", max_cnt);
        end
    endtask

    task automatic test_overflow();
        int pi[$];
        int pl[$];
        rdy = 1'b0;
        for (int k = 0; k < 9; k++) begin
            gnt = (k % 2 == 1) ? 256'h80 : 256'h01;
            tick();
        end
        total++;
        if (bus.fifo_full_o !== 1'b1 || bus.fifo_cnt_o !== 4'd8 || bus.ovf_o !== 1'b0) begin
            bad++; $display("FAIL ovf_fill: full=%b cnt=%0d ovf=%b, want 1 8 0", bus.fifo_full_o, bus.fifo_cnt_o, bus.ovf_o);
        end
        gnt = '0;
        tick();
        total++;
        if (bus.ovf_o !== 1'b1 || bus.fifo_cnt_o !== 4'd8 || bus.busy_o !== 1'b0) begin
            bad++; $display("FAIL ovf_drop: ovf=%b cnt=%0d busy=%b, want 1 8 0", bus.ovf_o, bus.fifo_cnt_o, bus.busy_o);
        end
        gnt = 256'h01; clr = 1'b1;
        tick();
        clr = 1'b0;
        total++;
        if (bus.ovf_o !== 1'b0 || bus.busy_o !== 1'b1) begin
            bad++; $display("FAIL ovf_clear: ovf=%b busy=%b, want 0 1", bus.ovf_o, bus.busy_o);
        end
        gnt = '0; rdy = 1'b1;
        if (bus.evt_valid_o) begin pi.push_back(int'(bus.evt_idx_o)); pl.push_back(int'(bus.evt_len_o)); end
        tick();
        total++;
        if (bus.fifo_cnt_o !== 4'd8 || bus.fifo_full_o !== 1'b1 || bus.ovf_o !== 1'b0) begin
            bad++; $display("FAIL full_push_pop: cnt=%0d full=%b ovf=%b, want 8 1 0", bus.fifo_cnt_o, bus.fifo_full_o, bus.ovf_o);
        end
        for (int i = 0; i < 12; i++) begin
            if (!bus.evt_valid_o) break;
            pi.push_back(int'(bus.evt_idx_o)); pl.push_back(int'(bus.evt_len_o));
            tick();
        end
        total++;
        if (pi.size() != 9) begin
            bad++; $display("FAIL drain_count: got %0d events, want 9", pi.size());
        end
        for (int j = 0; j < pi.size(); j++) begin
            total++;
            if (pi[j] != ((j % 2 == 1) ? 7 : 0) || pl[j] != 1) begin
                bad++; $display("FAIL drain_ev%0d: got (%0d,%0d), want (%0d,1)", j, pi[j], pl[j], (j % 2 == 1) ? 7 : 0);
            end
        end
        total++;
        if (bus.evt_valid_o !== 1'b0 || bus.fifo_cnt_o !== 4'd0) begin
            bad++; $display("FAIL drain_empty: valid=%b cnt=%0d, want 0 0", bus.evt_valid_o, bus.fifo_cnt_o);
        end
    endtask

    task automatic test_onehot();
        rdy = 1'b0; clr = 1'b0;
        gnt = 256'h13;
        tick();
        total++;
        if (bus.onehot_err_o !== 1'b1 || bus.busy_o !== 1'b0 || bus.evt_valid_o !== 1'b0) begin
            bad++; $display("FAIL multi_idle: err=%b busy=%b valid=%b, want 1 0 0", bus.onehot_err_o, bus.busy_o, bus.evt_valid_o);
        end
        gnt = 256'h04; clr = 1'b1;
        tick();
        clr = 1'b0;
        total++;
        if (bus.onehot_err_o !== 1'b0 || bus.busy_o !== 1'b1) begin
            bad++; $display("FAIL clr_err: err=%b busy=%b, want 0 1", bus.onehot_err_o, bus.busy_o);
        end
        tick(); tick();
        gnt = 256'h06;
        tick();
        total++;
        if (bus.evt_valid_o !== 1'b1 || bus.evt_idx_o !== 8'd2 || bus.evt_len_o !== 16'd3 ||
            bus.busy_o !== 1'b0 || bus.onehot_err_o !== 1'b1) begin
            bad++; $display("FAIL multi_hold: valid=%b idx=%0d len=%0d busy=%b err=%b, want 1 2 3 0 1",
                bus.evt_valid_o, bus.evt_idx_o, bus.evt_len_o, bus.busy_o, bus.onehot_err_o);
        end
        gnt = '0; clr = 1'b1;
        tick();
        clr = 1'b0;
        total++;
        if (bus.onehot_err_o !== 1'b0) begin
            bad++; $display("FAIL clr_pulse: err=%b, want 0", bus.onehot_err_o);
        end
        gnt = 256'h03; clr = 1'b1;
        tick();
        clr = 1'b0;
        total++;
        if (bus.onehot_err_o !== 1'b1) begin
            bad++; $display("FAIL set_wins: err=%b, want 1", bus.onehot_err_o);
        end
        gnt = '0; clr = 1'b1; rdy = 1'b1;
        tick();
        clr = 1'b0; rdy = 1'b0;
        total++;
        if (bus.onehot_err_o !== 1'b0 || bus.evt_valid_o !== 1'b0) begin
            bad++; $display("FAIL onehot_end: err=%b valid=%b, want 0 0", bus.onehot_err_o, bus.evt_valid_o);
        end
    endtask

    task automatic test_saturation();
        rst = 1'b1; gnt = '0; rdy = 1'b0; clr = 1'b0;
        tick();
        rst = 1'b0;
        gnt[255] = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        gnt = '0;
        tick();
        total++;
        if (bus.evt_valid_o !== 1'b1 || bus.evt_idx_o !== 8'd255 || bus.evt_len_o !== 16'd20) begin
            bad++; $display("FAIL long_tenure: valid=%b idx=%0d len=%0d, want 1 255 20", bus.evt_valid_o, bus.evt_idx_o, bus.evt_len_o);
        end
        total++;
        if (bus_s.evt_valid_o !== 1'b1 || bus_s.evt_idx_o !== 8'd255 || bus_s.evt_len_o !== 4'd15) begin
            bad++; $display("FAIL saturate: valid=%b idx=%0d len=%0d, want 1 255 15", bus_s.evt_valid_o, bus_s.evt_idx_o, bus_s.evt_len_o);
        end
    endtask

    task automatic test_reset_mid();
        rst = 1'b1; gnt = '0; rdy = 1'b0; clr = 1'b0;
        tick();
        rst = 1'b0;
        gnt = 256'h03; tick();
        gnt = 256'h01; tick();
        gnt = 256'h02; tick();
        gnt = 256'h04; tick();
        gnt = 256'h08; tick();
        total++;
        if (bus.fifo_cnt_o !== 4'd3 || bus.busy_o !== 1'b1 || bus.onehot_err_o !== 1'b1) begin
            bad++; $display("FAIL mid_setup: cnt=%0d busy=%b err=%b, want 3 1 1", bus.fifo_cnt_o, bus.busy_o, bus.onehot_err_o);
        end
        rst = 1'b1;
        tick();
        total++;
        if ({bus.evt_valid_o, bus.fifo_cnt_o, bus.busy_o, bus.ovf_o, bus.onehot_err_o} !== '0) begin
            bad++; $display("FAIL mid_reset: valid=%b cnt=%0d busy=%b ovf=%b err=%b, want all 0",
                bus.evt_valid_o, bus.fifo_cnt_o, bus.busy_o, bus.ovf_o, bus.onehot_err_o);
        end
        rst = 1'b0; gnt = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (bus.evt_valid_o !== 1'b0 || bus.fifo_cnt_o !== 4'd0) begin
                bad++; $display("FAIL stale_event_%0d: valid=%b cnt=%0d, want 0 0", i, bus.evt_valid_o, bus.fifo_cnt_o);
            end
        end
    endtask

    task automatic test_random();
        int mode, a, b, sz;
        logic [8:0] exp_st;
        logic [8:0] got_st;
        rst = 1'b1; gnt = '0; clr = 1'b0; rdy = 1'b0;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            mode = int'($urandom_range(99));
            if (mode < 45) begin
            end else if (mode < 60) begin
                gnt = '0;
            end else if (mode < 90) begin
                a = ($urandom_range(3) == 0) ? int'($urandom_range(255)) : int'($urandom_range(3));
                gnt = '0; gnt[a] = 1'b1;
            end else begin
                a = int'($urandom_range(255));
                b = (a + 1 + int'($urandom_range(254))) % 256;
                gnt = '0; gnt[a] = 1'b1; gnt[b] = 1'b1;
            end
            rdy = ($urandom_range(99) < (((c % 400) < 200) ? 20 : 70));
            clr = ($urandom_range(99) < 4);
            rst = ($urandom_range(999) < 3);
            tick();
            sz = mq_idx.size();
            exp_st = {(sz != 0), m_active, (sz == DEPTH), m_ovf, m_err, 4'(sz)};
            got_st = {bus.evt_valid_o, bus.busy_o, bus.fifo_full_o, bus.ovf_o, bus.onehot_err_o, bus.fifo_cnt_o};
            total++;
            if (got_st !== exp_st) begin
                bad++; $display("FAIL rand_status cyc %0d: got %b want %b (valid busy full ovf err cnt)", c, got_st, exp_st);
            end
            if (sz != 0) begin
                total++;
                if (bus.evt_idx_o !== 8'(mq_idx[0]) || bus.evt_len_o !== 16'(mq_len[0])) begin
                    bad++; $display("FAIL rand_head cyc %0d: got (%0d,%0d) want (%0d,%0d)",
                        c, bus.evt_idx_o, bus.evt_len_o, mq_idx[0], mq_len[0]);
                end
            end
        end
        rst = 1'b0; clr = 1'b0; rdy = 1'b0; gnt = '0;
    endtask

    initial begin
        test_reset();
        test_two_tenures();
        test_overflow();
        test_onehot();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rra_grant_logger.md
Name: rra_grant_logger

Overview:
Downstream companion to the round-robin arbiter. Consumes the arbiter's one-hot grant vector and records each grant tenure as an event {granted index, tenure length in cycles}. Events are buffered in a small FIFO and drained by a consumer over a valid/ready handshake. It also flags illegal (multi-hot) grant vectors and FIFO overflow as sticky status bits.

Parameters:
NUM_REQUESTS, 256, width of the grant vector
IDX_W, 8, width of the encoded grant index; must equal clog2(NUM_REQUESTS)
CNT_W, 16, width of the tenure-length counter
FIFO_DEPTH, 8, number of event entries; power of two, at least 2

Ports:
Pclk_i  input  1  clock
PReset_i  input  1  synchronous reset, active high
gnt_i  input  NUM_REQUESTS  grant vector from the arbiter (gnt_o)
clr_i  input  1  clears the sticky flags
evt_ready_i  input  1  consumer accepts the head event
evt_valid_o  output  1  FIFO is non-empty; head event is valid
evt_idx_o  output  IDX_W  grant index of the head event
evt_len_o  output  CNT_W  tenure length of the head event
fifo_cnt_o  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy
fifo_full_o  output  1  occupancy equals FIFO_DEPTH
busy_o  output  1  a tenure is in progress (state HOLD)
ovf_o  output  1  sticky: at least one event was dropped
onehot_err_o  output  1  sticky: multi-hot gnt_i was seen

Behaviour:
- Reset: all outputs 0, state IDLE, FIFO empty, pointers 0, counter 0. Reset mid-tenure discards the tenure and all buffered events.
- gnt_i is sampled every rising edge. Classification:
  - ZERO: no bits set.
  - ONE: exactly one bit set.
  - MULTI: two or more bits set.
- Index encoding: the position of the set bit. Bit 0 gives 0; bit NUM_REQUESTS-1 gives NUM_REQUESTS-1.
- State machine: IDLE / HOLD. The block holds held_vec, held_idx and len.
- IDLE:
  - ONE: latch vector and index, set len=1, go to HOLD.
  - ZERO: stay in IDLE.
  - MULTI: set onehot_err_o, stay in IDLE.
- HOLD:
  - gnt_i equals held_vec: len increments, saturating at 2^CNT_W-1.
  - Anything else ends the tenure: push {held_idx, len} at the same edge.
  - If the ending edge sees ONE: start a new tenure in the same edge (len=1, stay in HOLD). No idle gap is needed between back-to-back grants.
  - If the ending edge sees ZERO: go to IDLE.
  - If the ending edge sees MULTI: go to IDLE and set onehot_err_o.
- FIFO:
  - First-word fall-through. evt_valid_o, evt_idx_o and evt_len_o are driven from the head entry.
  - evt_valid_o is high in the cycle after the pushing edge.
  - A pop occurs on an edge where evt_valid_o and evt_ready_i are both high. The next entry appears in the following cycle.
  - evt_idx_o and evt_len_o hold their value while evt_valid_o is high and no pop occurs.
  - evt_idx_o and evt_len_o are don't-care when evt_valid_o is low.
- FIFO boundaries:
  - Pop when empty: ignored.
  - Push when full with no pop in the same edge: the event is dropped, ovf_o is set, and the FIFO is unchanged.
  - Push and pop in the same edge while full: both succeed; occupancy stays at FIFO_DEPTH.
  - Push and pop in the same edge while empty: not possible, since evt_valid_o=0.
  - Pointers wrap modulo FIFO_DEPTH.
- Sticky flags: clr_i clears ovf_o and onehot_err_o. If a set condition occurs in the same edge as clr_i, set wins.
- Status outputs:
  - fifo_cnt_o and fifo_full_o are registered and reflect post-edge occupancy.
  - busy_o is high exactly when state is HOLD.

Test Plan:
1. Reset held 2 cycles with gnt_i=0x11 -> all outputs 0; after release with gnt_i=0 -> evt_valid_o=0, fifo_cnt_o=0.
2. gnt_i=0x10 for 3 cycles, then 0x02 for 2 cycles, then 0, with evt_ready_i=1 -> events (idx 4, len 3) then (idx 1, len 2); fifo_cnt_o never exceeds 1; busy_o high for 5 cycles.
3. evt_ready_i=0; gnt_i alternates 0x01 / 0x80 for 9 single-cycle tenures, then 0 -> fifo_full_o after 8 pushes; 9th event dropped with ovf_o=1; draining returns idx 0,7,0,7,0,7,0,7, each len 1; then a pop and a push in the same edge while full -> occupancy stays 8.
4. gnt_i=0x13 in IDLE -> onehot_err_o=1, busy_o=0, no event. In HOLD on 0x04, gnt_i=0x06 -> event (2, n) pushed and state IDLE. clr_i pulse -> onehot_err_o=0. clr_i in the same edge as a new MULTI -> flag remains 1.
5. CNT_W=4; gnt_i=0x100... bit 255 held 20 cycles, then 0 -> event idx 255, len 15 (saturated).
6. Three events buffered and a tenure active; PReset_i=1 for one cycle -> evt_valid_o=0, fifo_cnt_o=0, busy_o=0, flags 0; no stale event appears after release.
